// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and the saturation helper for the FFT power averager.
package fft_pkg;
   localparam int N_DEFAULT = 256;
   localparam int ADDR_W    = $clog2(N_DEFAULT);
   localparam int SAT_W     = 128;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   // True when v does not fit in ow unsigned bits, i.e. it must be clamped.
   function automatic logic sat_over(input logic [SAT_W-1:0] v, input int ow);
      return (v >> ow) != {SAT_W{1'b0}};
   endfunction
endpackage

// File: rtl/fft_power_sq.sv
// Three-stage |X|^2 pipeline: register, square, sum/shift/saturate. A tag rides
// alongside each bin so the buffer address and frame flags stay aligned.
module fft_power_sq
   import fft_pkg::*;
#(
   parameter int DW    = 32,
   parameter int OW    = 32,
   parameter int SHIFT = 24,
   parameter int AW    = 8,
   parameter int TW    = 10
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   input  logic [TW-1:0]        in_tag,
   output logic                 s2_valid,
   output logic [AW-1:0]        s2_addr,
   output logic                 s3_valid,
   output logic [TW-1:0]        s3_tag,
   output logic [OW-1:0]        s3_pwr,
   output logic                 busy
);
   localparam int PW = 2*DW + 1;

   logic                   s1_valid;
   logic signed [DW-1:0]   s1_re, s1_im;
   logic [TW-1:0]          s1_tag, s2_tag;
   logic signed [2*DW-1:0] s2_re2, s2_im2;
   logic [PW-1:0]          sum, shifted;
   logic                   over;

   // Sum of squares cannot be negative, so it is treated as unsigned.
   always_comb begin
      sum     = PW'($unsigned(s2_re2)) + PW'($unsigned(s2_im2));
      shifted = sum >> SHIFT;
      over    = sat_over(SAT_W'(shifted), OW);
   end

   // Pipeline stages S1..S3 with valid bits cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         s1_re    <= {DW{1'b0}};
         s1_im    <= {DW{1'b0}};
         s1_tag   <= {TW{1'b0}};
         s2_re2   <= {(2*DW){1'b0}};
         s2_im2   <= {(2*DW){1'b0}};
         s2_tag   <= {TW{1'b0}};
         s3_tag   <= {TW{1'b0}};
         s3_pwr   <= {OW{1'b0}};
      end else begin
         s1_valid <= in_valid;
         s1_re    <= in_re;
         s1_im    <= in_im;
         s1_tag   <= in_tag;
         s2_valid <= s1_valid;
         s2_re2   <= (2*DW)'(s1_re) * (2*DW)'(s1_re);
         s2_im2   <= (2*DW)'(s1_im) * (2*DW)'(s1_im);
         s2_tag   <= s1_tag;
         s3_valid <= s2_valid;
         s3_tag   <= s2_tag;
         s3_pwr   <= over ? {OW{1'b1}} : shifted[OW-1:0];
      end
   end

   assign s2_addr = s2_tag[AW-1:0];
   assign busy    = s1_valid | s2_valid | s3_valid;
endmodule

// File: rtl/fft_power_avg.sv
// Per-bin power averaging over 2^AVG_LOG2 FFT frames, valid/ready drain of the
// averaged spectrum and peak-bin search; holds the FFT off while draining.
module fft_power_avg
   import fft_pkg::*;
#(
   parameter int N        = N_DEFAULT,
   parameter int DW       = 32,
   parameter int OW       = 32,
   parameter int SHIFT    = 24,
   parameter int AVG_LOG2 = 2,
   parameter int SKIP_DC  = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] X_re_i,
   input  logic signed [DW-1:0] X_im_i,
   input  logic                 fft_ready_i,
   input  logic                 fft_done_i,
   output logic                 dl_busy_o,
   output logic [OW-1:0]        pwr_o,
   output logic [$clog2(N)-1:0] bin_o,
   output logic                 pwr_valid_o,
   input  logic                 pwr_ready_i,
   output logic [$clog2(N)-1:0] peak_bin_o,
   output logic [OW-1:0]        peak_pwr_o,
   output logic                 peak_valid_o,
   output logic                 err_o
);
   localparam int AW = $clog2(N);
   localparam int BW = OW + AVG_LOG2;
   localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int TW = AW + 2;
   localparam logic [AW-1:0] BIN_LAST = AW'(N - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'((32'd1 << AVG_LOG2) - 32'd1);

   state_t        state, state_next;
   logic [AW-1:0] bin_cnt, rd_addr, rd_bin, run_bin, bin_next;
   logic [FW-1:0] frm_cnt;
   logic [AW:0]   rd_cnt;
   logic [TW-1:0] tag, s3_tag;
   logic [AW-1:0] s2_addr;
   logic [OW-1:0] s3_pwr, run_max, max_next;
   logic [BW-1:0] mem [N];
   logic [BW-1:0] rd_data, wr_data;
   logic accept, short_frame, frame_last, s2_valid, s3_valid, pipe_busy;
   logic rd_en, rd_pend, issue, load, hs, last_hs, better;

   fft_power_sq #(.DW(DW), .OW(OW), .SHIFT(SHIFT), .AW(AW), .TW(TW)) u_sq (
      .clk(clk), .rst(rst), .in_valid(accept), .in_re(X_re_i), .in_im(X_im_i),
      .in_tag(tag), .s2_valid(s2_valid), .s2_addr(s2_addr), .s3_valid(s3_valid),
      .s3_tag(s3_tag), .s3_pwr(s3_pwr), .busy(pipe_busy)
   );

   // Tag = {last bin of last frame, first frame, bin}; drain reads wait for an empty pipe.
   always_comb begin
      accept      = fft_ready_i && (state == ACCUM);
      short_frame = fft_done_i && (state == ACCUM) && (bin_cnt != {AW{1'b0}});
      frame_last  = (bin_cnt == BIN_LAST) && (frm_cnt == FRM_LAST);
      tag         = {frame_last, frm_cnt == {FW{1'b0}}, bin_cnt};
      hs          = pwr_valid_o && pwr_ready_i;
      last_hs     = hs && (bin_o == BIN_LAST);
      load        = (state == DRAIN) && rd_pend && (!pwr_valid_o || pwr_ready_i);
      issue       = (state == DRAIN) && !rd_cnt[AW] && (!rd_pend || load) && !pipe_busy;
      rd_en       = issue || s2_valid;
      rd_addr     = issue ? rd_cnt[AW-1:0] : s2_addr;
      wr_data     = s3_tag[AW] ? BW'(s3_pwr) : rd_data + BW'(s3_pwr);
      better      = ((SKIP_DC == 0) || (bin_o != {AW{1'b0}})) && (pwr_o > run_max);
      max_next    = better ? pwr_o : run_max;
      bin_next    = better ? bin_o : run_bin;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ACCUM: begin
            if (s3_valid && s3_tag[AW+1]) state_next = DRAIN;
            else                          state_next = ACCUM;
         end
         DRAIN: begin
            if (last_hs) state_next = DONE;
            else         state_next = DRAIN;
         end
         DONE:    state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // Simple dual-port buffer: write from S3, registered read.
   always_ff @(posedge clk) begin
      if (s3_valid) mem[s3_tag[AW-1:0]] <= wr_data;
      if (rd_en)    rd_data <= mem[rd_addr];
   end

   // State register plus bin/frame counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ACCUM;
         bin_cnt <= {AW{1'b0}};
         frm_cnt <= {FW{1'b0}};
      end else begin
         state <= state_next;
         if (state == DONE) begin
            bin_cnt <= {AW{1'b0}};
            frm_cnt <= {FW{1'b0}};
         end else if (short_frame) begin
            bin_cnt <= {AW{1'b0}};
         end else if (accept) begin
            bin_cnt <= bin_cnt + 1'b1;
            if (bin_cnt == BIN_LAST)
               frm_cnt <= (frm_cnt == FRM_LAST) ? {FW{1'b0}} : frm_cnt + 1'b1;
         end
      end
   end

   // Drain read sequencer and running peak; idle outside DRAIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt  <= {(AW+1){1'b0}};
         rd_pend <= 1'b0;
         rd_bin  <= {AW{1'b0}};
         run_max <= {OW{1'b0}};
         run_bin <= {AW{1'b0}};
      end else if (state != DRAIN) begin
         rd_cnt  <= {(AW+1){1'b0}};
         rd_pend <= 1'b0;
         run_max <= {OW{1'b0}};
         run_bin <= {AW{1'b0}};
      end else begin
         if (issue) begin
            rd_cnt  <= rd_cnt + 1'b1;
            rd_pend <= 1'b1;
            rd_bin  <= rd_cnt[AW-1:0];
         end else if (load) begin
            rd_pend <= 1'b0;
         end
         if (hs) begin
            run_max <= max_next;
            run_bin <= bin_next;
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_busy_o    <= 1'b0;
         pwr_o        <= {OW{1'b0}};
         bin_o        <= {AW{1'b0}};
         pwr_valid_o  <= 1'b0;
         peak_bin_o   <= {AW{1'b0}};
         peak_pwr_o   <= {OW{1'b0}};
         peak_valid_o <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         dl_busy_o    <= (state_next == DRAIN);
         peak_valid_o <= last_hs;
         if (load) begin
            pwr_o       <= OW'(rd_data >> AVG_LOG2);
            bin_o       <= rd_bin;
            pwr_valid_o <= 1'b1;
         end else if (hs) begin
            pwr_valid_o <= 1'b0;
         end
         if (last_hs) begin
            peak_pwr_o <= max_next;
            peak_bin_o <= bin_next;
         end
         if ((fft_ready_i && (state != ACCUM)) || short_frame) err_o <= 1'b1;
      end
   end
endmodule
